// File: rtl/m_fetch_unit_pkg.sv
// Shared constants and fetch FSM encoding for the fetch stage and its neighbours.
package m_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BUF_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/m_fetch_fifo.sv
// Circular fetch buffer holding {pc, instr} entries; head is read straight from storage.
module m_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_en;
  logic             push_en;

  // Pop on empty is ignored; push on full is only taken alongside a pop.
  assign pop_en  = pop_i && (count_q != '0);
  assign push_en = push_i && ((count_q != CW'(DEPTH)) || pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/m_fetch_unit.sv
// Fetch stage: one outstanding imem request at a time, PC back-pressure, flush discard.
module m_fetch_unit
  import m_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [DATA_W-1:0] dec_instr,
  input  logic              dec_ready
);

  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_valid_c;
  logic              stall_c;
  logic              fifo_push;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              space;

  // The outstanding request is already reflected in the state, so IDLE only needs count.
  assign space = (fifo_count < CW'(BUF_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    req_valid_c = 1'b0;
    stall_c     = 1'b1;
    fifo_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_valid_c = reset && !flush && space;
        if (req_valid_c && imem_req_ready) begin
          req_pc_d = pc_in;
          state_d  = ST_WAIT;
          stall_c  = 1'b0;
        end
      end
      ST_WAIT: begin
        // A response landing with a flush retires the request but is not buffered.
        if (imem_resp_valid) begin
          fifo_push = !flush;
          state_d   = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush)  stall_c = 1'b0;
    if (!reset) stall_c = 1'b1;
  end

  m_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .pop_i   (dec_ready),
    .flush_i (flush),
    .wdata_i ({req_pc_q, imem_resp_data}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (fifo_push && fifo_full) |-> dec_ready);

  assign pc_stall       = stall_c;
  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = reset ? pc_in : '0;
  assign dec_valid      = !fifo_empty;
  assign dec_pc         = fifo_head[EW-1 -: ADDR_W];
  assign dec_instr      = fifo_head[DATA_W-1:0];

endmodule
